// File: rtl/cpu_pkg.sv
// Shared types for the fetch front-end.
//   If_Of_t    : payload handed from IF to OF, {pc, instr}.
//   if_state_e : IF stage FSM states.
//   pc_inc     : sequential next fetch address (wraps modulo 2^32).
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } If_Of_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } if_state_e;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one word fetch at a time to instruction
// memory, holds the returned word in an output register until OF accepts it,
// and follows redirects from EX, discarding responses to abandoned fetches.
// Ports:
//   Clk, Rst                      clock, synchronous active-high reset
//   Imem_Req_o / Imem_Addr_o      fetch request strobe and word-aligned address
//   Imem_Rvalid_i / Imem_Rdata_i  fetch response (arbitrary latency, in order)
//   Br_Taken_i / Br_Target_i      redirect from EX
//   If_Payld_o / If_Valid_o       {pc, instr} payload and its valid to OF
//   Of_Ready_i                    OF accepts the payload
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        Imem_Req_o,
  output logic [31:0] Imem_Addr_o,
  input  logic        Imem_Rvalid_i,
  input  logic [31:0] Imem_Rdata_i,
  input  logic        Br_Taken_i,
  input  logic [31:0] Br_Target_i,
  output If_Of_t      If_Payld_o,
  output logic        If_Valid_o,
  input  logic        Of_Ready_i
);

  if_state_e   r_state, w_state_n;
  logic [31:0] r_pc, w_pc_n;
  If_Of_t      r_payld;
  // Count of in-flight responses that must be thrown away. A reset in WAIT
  // leaves the pre-reset fetch in flight while the post-reset fetch is issued
  // at once, so up to two can be outstanding; hence a count, not a flag.
  logic [1:0]  r_drop_cnt, w_drop_n;
  // In WAIT: the outstanding fetch for pc is still wanted (not redirected).
  logic        r_live, w_live_n;
  logic        w_capture;
  logic [31:0] w_target;
  logic [1:0]  w_outstanding;
  logic [1:0]  w_rst_drop;

  assign w_target    = Br_Target_i & ~32'h3;
  assign Imem_Addr_o = r_pc;
  assign If_Payld_o  = r_payld;

  // Responses still owed by memory when reset hits; this cycle's response
  // (if any) settles the oldest of them.
  assign w_outstanding = r_drop_cnt + {1'b0, (r_state == WAIT) && r_live};
  assign w_rst_drop    = (Imem_Rvalid_i && (w_outstanding != 2'd0)) ?
                         w_outstanding - 2'd1 : w_outstanding;

  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_drop_n   = r_drop_cnt;
    w_live_n   = r_live;
    w_capture  = 1'b0;
    Imem_Req_o = 1'b0;
    If_Valid_o = 1'b0;

    // Discarded responses precede any live one, so any response seen while
    // the count is non-zero belongs to an abandoned fetch.
    if (Imem_Rvalid_i && (r_drop_cnt != 2'd0)) begin
      w_drop_n = r_drop_cnt - 2'd1;
    end

    case (r_state)
      FETCH: begin
        if (Br_Taken_i) begin
          w_pc_n = w_target;
        end else begin
          Imem_Req_o = 1'b1;
          w_live_n   = 1'b1;
          w_state_n  = WAIT;
        end
      end
      WAIT: begin
        if (Imem_Rvalid_i && (r_drop_cnt == 2'd0)) begin
          w_live_n = 1'b0;
          if (Br_Taken_i) begin
            w_pc_n    = w_target;
            w_state_n = FETCH;
          end else begin
            w_capture = 1'b1;
            w_state_n = HOLD;
          end
        end else begin
          if (Br_Taken_i) begin
            w_pc_n = w_target;
            if (r_live) begin
              w_live_n = 1'b0;
              w_drop_n = w_drop_n + 2'd1;
            end
          end
          if ((w_drop_n == 2'd0) && !w_live_n) begin
            w_state_n = FETCH;
          end
        end
      end
      HOLD: begin
        If_Valid_o = !Br_Taken_i;
        if (Br_Taken_i) begin
          w_pc_n    = w_target;
          w_state_n = FETCH;
        end else if (Of_Ready_i) begin
          w_pc_n    = pc_inc(r_pc);
          w_state_n = FETCH;
        end
      end
      default: w_state_n = FETCH;
    endcase

    if (Rst) begin
      Imem_Req_o = 1'b0;
      If_Valid_o = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= FETCH;
      r_pc       <= RESET_PC;
      r_drop_cnt <= w_rst_drop;
      r_live     <= 1'b0;
      r_payld    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_drop_cnt <= w_drop_n;
      r_live     <= w_live_n;
      if (w_capture) begin
        r_payld <= '{pc: r_pc, instr: Imem_Rdata_i};
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Imem_Req_o;
  logic [31:0] Imem_Addr_o;
  logic        Imem_Rvalid_i = 1'b0;
  logic [31:0] Imem_Rdata_i  = '0;
  logic        Br_Taken_i;
  logic [31:0] Br_Target_i;
  If_Of_t      If_Payld_o;
  logic        If_Valid_o;
  logic        Of_Ready_i;

  always #5 Clk = ~Clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst(Rst),
    .Imem_Req_o(Imem_Req_o), .Imem_Addr_o(Imem_Addr_o),
    .Imem_Rvalid_i(Imem_Rvalid_i), .Imem_Rdata_i(Imem_Rdata_i),
    .Br_Taken_i(Br_Taken_i), .Br_Target_i(Br_Target_i),
    .If_Payld_o(If_Payld_o), .If_Valid_o(If_Valid_o),
    .Of_Ready_i(Of_Ready_i)
  );

  int          n_vec = 0;
  int          n_mis = 0;
  int unsigned cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- memory: in-order responses after 'lat' cycles ----------
  typedef struct {int unsigned due; logic [31:0] addr;} mreq_t;
  mreq_t       mq[$];
  int unsigned lat = 1;
  int unsigned last_due = 0;

  always @(negedge Clk) begin
    int unsigned d;
    if (Imem_Req_o === 1'b1) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{due: d, addr: Imem_Addr_o});
    end
  end

  always @(posedge Clk) begin
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      Imem_Rvalid_i = 1'b1;
      Imem_Rdata_i  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      Imem_Rvalid_i = 1'b0;
      Imem_Rdata_i  = 32'hDEAD_DEAD;
    end
  end

  // ---------------- transaction-level reference model + compare -----------
  // Outstanding fetches tagged: 0 wanted, 1 abandoned by redirect,
  // 2 abandoned by reset (the latter does not hold back the next fetch).
  typedef struct {logic [31:0] addr; int tag;} oreq_t;
  oreq_t       oq[$];
  bit          held = 0;
  logic [31:0] held_pc = '0;
  logic [31:0] exp_addr = RST_PC;

  logic [31:0] req_addr_log[$];
  int unsigned req_cyc_log[$];
  bit          watch8 = 0, seen8 = 0;
  bit          watch_first = 0, first_got = 0;
  logic [31:0] first_pc, first_instr;

  always @(negedge Clk) begin
    bit    e_req, e_val;
    int    nblock;
    oreq_t e;
    nblock = 0;
    foreach (oq[i]) if (oq[i].tag != 2) nblock++;
    if (Rst) begin
      e_req = 0;
      e_val = 0;
    end else begin
      e_val = held && !Br_Taken_i;
      e_req = !Br_Taken_i && !held && (nblock == 0);
    end
    chk("req", {31'd0, Imem_Req_o}, {31'd0, e_req});
    chk("valid", {31'd0, If_Valid_o}, {31'd0, e_val});
    if (e_req) chk("addr", Imem_Addr_o, exp_addr);
    if (e_val) begin
      chk("payld_pc", If_Payld_o.pc, held_pc);
      chk("payld_instr", If_Payld_o.instr, mem_word(held_pc));
    end

    if (Imem_Req_o === 1'b1) begin
      req_addr_log.push_back(Imem_Addr_o);
      req_cyc_log.push_back(cyc);
    end
    if (If_Valid_o === 1'b1) begin
      if (watch8 && If_Payld_o.pc == 32'h8) seen8 = 1;
      if (watch_first && !first_got) begin
        first_got   = 1;
        first_pc    = If_Payld_o.pc;
        first_instr = If_Payld_o.instr;
      end
    end

    if (Rst) begin
      foreach (oq[i]) oq[i].tag = 2;
      if (Imem_Rvalid_i && oq.size() > 0) void'(oq.pop_front());
      held     = 0;
      exp_addr = RST_PC;
    end else begin
      if (e_val && Of_Ready_i) begin
        held     = 0;
        exp_addr = exp_addr + 32'd4;
      end
      if (Imem_Rvalid_i && oq.size() > 0) begin
        e = oq.pop_front();
        if (e.tag == 0 && !Br_Taken_i) begin
          held    = 1;
          held_pc = e.addr;
        end
      end
      if (Br_Taken_i) begin
        foreach (oq[i]) if (oq[i].tag == 0) oq[i].tag = 1;
        held     = 0;
        exp_addr = {Br_Target_i[31:2], 2'b00};
      end
      if (e_req) oq.push_back('{addr: exp_addr, tag: 0});
    end
  end

  // ---------------- bounded waits -------------------------------------------
  task automatic wait_next_req(input string nm, input int budget,
                               output logic [31:0] a, output int unsigned c);
    int unsigned n;
    bit          found;
    n     = req_addr_log.size();
    found = 0;
    a     = 'x;
    c     = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (req_addr_log.size() > n) begin
        a     = req_addr_log[n];
        c     = req_cyc_log[n];
        found = 1;
      end
    end
    if (!found) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: no request within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_req(input string nm, input logic [31:0] want, input int budget);
    logic [31:0] a;
    int unsigned c;
    bit          found;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      wait_next_req(nm, budget, a, c);
      if (a === want) found = 1;
    end
    if (!found) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: request to %h not seen, last %h", nm, want, a);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ---------------------------------------
  initial begin
    int unsigned rel, n, c;
    logic [31:0] a;
    bit          got;
    Rst = 1'b1; Br_Taken_i = 1'b0; Br_Target_i = '0; Of_Ready_i = 1'b1;
    tick();
    tick();
    chk("reset_payld_pc", If_Payld_o.pc, 32'h0);
    chk("reset_payld_instr", If_Payld_o.instr, 32'h0);
    chk("reset_req", {31'd0, Imem_Req_o}, 32'd0);
    chk("reset_valid", {31'd0, If_Valid_o}, 32'd0);

    // Streaming at one instruction per three cycles from RESET_PC.
    Rst = 1'b0;
    rel = cyc;
    n   = req_addr_log.size();
    repeat (9) tick();
    if (req_addr_log.size() < n + 3) begin
      chk("stream_req_count", req_addr_log.size() - n, 3);
    end else begin
      for (int k = 0; k < 3; k++) begin
        chk("stream_addr", req_addr_log[n + k], 32'(4 * k));
        chk("stream_cycle", req_cyc_log[n + k] - rel, 32'(3 * k));
      end
    end

    // OF stalls five cycles while pc 0x10 is held.
    wait_req("stall_setup", 32'h10, 20);
    Of_Ready_i = 1'b0;
    n = req_addr_log.size();
    repeat (6) tick();
    chk("stall_no_req", req_addr_log.size() - n, 0);
    chk("stall_valid", {31'd0, If_Valid_o}, 32'd1);
    chk("stall_pc", If_Payld_o.pc, 32'h10);
    Of_Ready_i = 1'b1;
    wait_next_req("after_stall", 10, a, c);
    chk("after_stall_addr", a, 32'h14);

    // Redirect to 0x103 while fetch of 0x8 is in flight (latency 4).
    lat = 4;
    Br_Taken_i = 1'b1; Br_Target_i = 32'h8;
    tick();
    Br_Taken_i = 1'b0;
    wait_req("fetch8", 32'h8, 20);
    watch8 = 1; seen8 = 0;
    Br_Taken_i = 1'b1; Br_Target_i = 32'h103;
    tick();
    Br_Taken_i = 1'b0;
    wait_next_req("after_drop", 20, a, c);
    chk("after_drop_addr", a, 32'h100);
    repeat (8) tick();
    chk("pc8_never_valid", {31'd0, seen8}, 32'd0);
    watch8 = 0;

    // Redirect in HOLD with OF ready: no transfer.
    lat = 1;
    Of_Ready_i = 1'b0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (If_Valid_o) got = 1;
    end
    chk("hold_reached", {31'd0, got}, 32'd1);
    Of_Ready_i = 1'b1; Br_Taken_i = 1'b1; Br_Target_i = 32'h40;
    #1;
    chk("hold_redirect_valid", {31'd0, If_Valid_o}, 32'd0);
    tick();
    Br_Taken_i = 1'b0;
    wait_next_req("after_hold_redirect", 10, a, c);
    chk("after_hold_redirect_addr", a, 32'h40);

    // Sequential wrap at the top of the address space; target low bits cleared.
    Br_Taken_i = 1'b1; Br_Target_i = 32'hFFFF_FFFF;
    tick();
    Br_Taken_i = 1'b0;
    wait_req("top_fetch", 32'hFFFF_FFFC, 20);
    wait_next_req("wrap", 20, a, c);
    chk("wrap_addr", a, 32'h0);

    // Reset while a fetch is in flight; stale word arrives two cycles later.
    lat = 3;
    wait_next_req("pre_reset", 20, a, c);
    Rst = 1'b1;
    watch_first = 1; first_got = 0;
    tick();
    Rst = 1'b0;
    wait_next_req("post_reset", 10, a, rel);
    chk("post_reset_addr", a, RST_PC);
    chk("post_reset_cycle", rel - c, 2);
    for (int i = 0; i < 20 && !first_got; i++) tick();
    chk("first_valid_seen", {31'd0, first_got}, 32'd1);
    chk("first_valid_pc", first_pc, RST_PC);
    chk("first_valid_instr", first_instr, mem_word(RST_PC));
    watch_first = 0;

    // Mixed traffic: intermittent ready, latency 2, one mid-stream redirect.
    lat = 2;
    for (int i = 0; i < 24; i++) begin
      Of_Ready_i = ((i % 3) != 1);
      Br_Taken_i = (i == 10);
      Br_Target_i = 32'h200;
      tick();
    end
    Br_Taken_i = 1'b0;
    Of_Ready_i = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
